// File: rtl/pc_gen.sv
// pc_gen: program-counter generator feeding the instruction-fetch stage.
// Produces the registered fetch address plus flush/advance controls, and
// tracks the PC of the word fetch is presenting to decode.
// Optional build macro: PC_GEN_MISALIGN_CHECK_EN (misaligned redirects
// raise misalign_o and park the generator in ERR until a trap).
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INCR         = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_vector_i,
  output logic [XLEN-1:0] target,
  output logic            flush,
  output logic            ok,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic            fetch_pc_valid_o,
  output logic            misalign_o
);

  typedef enum logic [2:0] {BOOT, RUN, STALL, REDIR, ERR} state_e;

  localparam logic [XLEN-1:0] IncrStep = XLEN'(INCR);
  localparam logic [XLEN-1:0] LowMask  = XLEN'(3);

  state_e          state_q, state_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            flush_q, flush_d;
  logic            ok_q, ok_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            fetch_pc_valid_q, fetch_pc_valid_d;

  logic            misalignHit;
  logic [XLEN-1:0] redirTarget;
  logic            trapTake;
  logic            redirAny;
  logic            redirTake;
  logic            errEnter;
  logic            stallTake;

`ifdef PC_GEN_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign misalignHit = |redirect_target_i[1:0];
  assign redirTarget = redirect_target_i;

  // Misalign flag is set on entry to ERR and only a trap clears it
  always_comb begin
    misalign_d = misalign_q;
    if (trapTake) begin
      misalign_d = 1'b0;
    end else if (errEnter) begin
      misalign_d = 1'b1;
    end
  end

  // Misalign flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;
`else
  assign misalignHit = 1'b0;
  assign redirTarget = redirect_target_i & ~LowMask;
  assign misalign_o  = 1'b0;
`endif

  // Event decode: trap beats redirect beats stall; ERR ignores all but trap;
  // the cycle right after a redirect never honours a stall
  always_comb begin
    trapTake  = trap_valid_i;
    redirAny  = !trap_valid_i && (state_q != ERR) && redirect_valid_i;
    errEnter  = redirAny && misalignHit;
    redirTake = redirAny && !misalignHit;
    stallTake = !trap_valid_i && (state_q != ERR) && !redirect_valid_i &&
                stall_i && (state_q != REDIR);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = RUN;
    if (trapTake || redirTake) begin
      state_d = REDIR;
    end else if (errEnter || (state_q == ERR)) begin
      state_d = ERR;
    end else if (stallTake) begin
      state_d = STALL;
    end
  end

  // Next values for the registered outputs; a word is consumed at any edge
  // where the pipeline was allowed to advance without a flush
  always_comb begin
    target_d         = target_q;
    flush_d          = 1'b0;
    ok_d             = 1'b0;
    fetch_pc_d       = fetch_pc_q;
    fetch_pc_valid_d = fetch_pc_valid_q;
    if (ok_q && !flush_q) begin
      fetch_pc_d       = target_q;
      fetch_pc_valid_d = 1'b1;
    end
    if (flush_q) begin
      fetch_pc_valid_d = 1'b0;
    end
    if (trapTake) begin
      target_d         = trap_vector_i;
      flush_d          = 1'b1;
      fetch_pc_valid_d = 1'b0;
    end else if (redirTake) begin
      target_d         = redirTarget;
      flush_d          = 1'b1;
      fetch_pc_valid_d = 1'b0;
    end else if (errEnter) begin
      flush_d          = 1'b1;
      fetch_pc_valid_d = 1'b0;
    end else if ((state_q == ERR) || stallTake) begin
      ok_d = 1'b0;
    end else begin
      ok_d = 1'b1;
      if (state_q != BOOT) begin
        target_d = target_q + IncrStep;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q         <= RESET_VECTOR;
      flush_q          <= 1'b1;
      ok_q             <= 1'b0;
      fetch_pc_q       <= '0;
      fetch_pc_valid_q <= 1'b0;
    end else begin
      target_q         <= target_d;
      flush_q          <= flush_d;
      ok_q             <= ok_d;
      fetch_pc_q       <= fetch_pc_d;
      fetch_pc_valid_q <= fetch_pc_valid_d;
    end
  end

  assign target           = target_q;
  assign flush            = flush_q;
  assign ok               = ok_q;
  assign fetch_pc_o       = fetch_pc_q;
  assign fetch_pc_valid_o = fetch_pc_valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios plus randomized traffic for pc_gen, checked
// against a transaction-level reference model of the fetch address stream.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h0000_0100;
`ifdef PC_GEN_MISALIGN_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic        trap_valid_i;
  logic [31:0] trap_vector_i;
  logic [31:0] target;
  logic        flush;
  logic        ok;
  logic [31:0] fetch_pc_o;
  logic        fetch_pc_valid_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  // Reference model: the address the generator presents, whether fetch may
  // advance, and the last word actually consumed by fetch
  logic [31:0] mTarget, mFetchPc;
  logic        mFlush, mOk, mValid, mMis;
  bit          mBoot, mAfterRedir, mErr;

  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .INCR(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .trap_valid_i      (trap_valid_i),
    .trap_vector_i     (trap_vector_i),
    .target            (target),
    .flush             (flush),
    .ok                (ok),
    .fetch_pc_o        (fetch_pc_o),
    .fetch_pc_valid_o  (fetch_pc_valid_o),
    .misalign_o        (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck run still reports
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mTarget = RV; mFlush = 1'b1; mOk = 1'b0; mFetchPc = '0; mValid = 1'b0;
    mMis = 1'b0; mBoot = 1'b1; mAfterRedir = 1'b0; mErr = 1'b0;
  endtask

  task automatic modelStep(input bit tr, input logic [31:0] tv, input bit rd,
                           input logic [31:0] rt, input bit st);
    bit wasBoot, wasRedir, badAlign;
    wasBoot  = mBoot;
    wasRedir = mAfterRedir;
    badAlign = CheckEn && (rt[1:0] != 2'b00);
    mBoot = 1'b0;
    mAfterRedir = 1'b0;
    if (mOk && !mFlush) begin
      mFetchPc = mTarget;
      mValid   = 1'b1;
    end
    if (mFlush) mValid = 1'b0;
    if (tr) begin
      mTarget = tv; mFlush = 1'b1; mOk = 1'b0; mValid = 1'b0;
      mMis = 1'b0; mErr = 1'b0; mAfterRedir = 1'b1;
    end else if (mErr) begin
      mFlush = 1'b0; mOk = 1'b0;
    end else if (rd && badAlign) begin
      mErr = 1'b1; mMis = 1'b1; mFlush = 1'b1; mOk = 1'b0; mValid = 1'b0;
    end else if (rd) begin
      mTarget = {rt[31:2], 2'b00}; mFlush = 1'b1; mOk = 1'b0;
      mValid = 1'b0; mAfterRedir = 1'b1;
    end else if (st && !wasRedir) begin
      mFlush = 1'b0; mOk = 1'b0;
    end else begin
      mFlush = 1'b0; mOk = 1'b1;
      if (!wasBoot) mTarget = mTarget + 32'd4;
    end
  endtask

  task automatic checkOutput();
    checkOne("target", target, mTarget);
    checkOne("flush", {31'b0, flush}, {31'b0, mFlush});
    checkOne("ok", {31'b0, ok}, {31'b0, mOk});
    checkOne("fetch_pc", fetch_pc_o, mFetchPc);
    checkOne("fetch_pc_valid", {31'b0, fetch_pc_valid_o}, {31'b0, mValid});
    checkOne("misalign", {31'b0, misalign_o}, {31'b0, mMis});
  endtask

  // One clock: drive inputs, advance model on the edge, compare on negedge
  task automatic applyStimulus(input bit tr, input logic [31:0] tv, input bit rd,
                               input logic [31:0] rt, input bit st, input bit rs);
    rst = rs; trap_valid_i = tr; trap_vector_i = tv;
    redirect_valid_i = rd; redirect_target_i = rt; stall_i = st;
    @(posedge clk);
    if (rs) modelReset();
    else modelStep(tr, tv, rd, rt, st);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic redirectTo(input logic [31:0] a);
    applyStimulus(1'b0, 32'h0, 1'b1, a, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_target_i = '0;
    trap_valid_i = 1'b0; trap_vector_i = '0;
    @(negedge clk);

    // Reset state
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOne("rst_target", target, 32'h100);
    checkOne("rst_flush", {31'b0, flush}, 32'd1);
    checkOne("rst_ok", {31'b0, ok}, 32'd0);

    // Reset release, free running
    idle();
    checkOne("boot_target", target, 32'h100);
    checkOne("boot_ok", {31'b0, ok}, 32'd1);
    idle();
    checkOne("seq1_target", target, 32'h104);
    checkOne("seq1_fetch_pc", fetch_pc_o, 32'h100);
    idle();
    checkOne("seq2_target", target, 32'h108);
    idle();
    checkOne("seq3_target", target, 32'h10C);
    checkOne("seq3_fetch_pc", fetch_pc_o, 32'h108);

    // Stall for three cycles at 0x200
    redirectTo(32'h1FC);
    idle();
    checkOne("pre_stall_target", target, 32'h200);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      checkOne("stall_hold_target", target, 32'h200);
      checkOne("stall_ok", {31'b0, ok}, 32'd0);
    end
    idle();
    checkOne("unstall_target1", target, 32'h204);
    idle();
    checkOne("unstall_target2", target, 32'h208);
    checkOne("unstall_fetch_pc", fetch_pc_o, 32'h204);

    // Redirect to 0x400 from 0x120
    redirectTo(32'h11C);
    idle();
    checkOne("at_120", target, 32'h120);
    redirectTo(32'h400);
    checkOne("redir_target", target, 32'h400);
    checkOne("redir_flush", {31'b0, flush}, 32'd1);
    checkOne("redir_valid", {31'b0, fetch_pc_valid_o}, 32'd0);
    idle();
    checkOne("redir_next", target, 32'h404);
    checkOne("redir_next_ok", {31'b0, ok}, 32'd1);

    // Trap and redirect together during a stall
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h80, 1'b1, 32'h400, 1'b1, 1'b0);
    checkOne("trap_target", target, 32'h80);
    checkOne("trap_flush", {31'b0, flush}, 32'd1);
    idle();
    checkOne("trap_next", target, 32'h84);

    // Address wrap
    redirectTo(32'hFFFF_FFF8);
    idle();
    checkOne("wrap_fc", target, 32'hFFFF_FFFC);
    idle();
    checkOne("wrap_zero", target, 32'h0);

    // Misaligned redirect
    redirectTo(32'h402);
    if (CheckEn) begin
      checkOne("mis_flag", {31'b0, misalign_o}, 32'd1);
      checkOne("mis_hold_target", target, 32'h0);
      checkOne("mis_ok", {31'b0, ok}, 32'd0);
      idle();
      checkOne("mis_sticky", {31'b0, misalign_o}, 32'd1);
      checkOne("mis_flush_drop", {31'b0, flush}, 32'd0);
      applyStimulus(1'b0, 32'h0, 1'b1, 32'h500, 1'b1, 1'b0);
      checkOne("mis_ignore_redir", target, 32'h0);
      applyStimulus(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOne("mis_trap_clear", {31'b0, misalign_o}, 32'd0);
      checkOne("mis_trap_target", target, 32'h80);
    end else begin
      checkOne("nomis_target", target, 32'h400);
      checkOne("nomis_flag", {31'b0, misalign_o}, 32'd0);
    end
    idle();

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      bit tr, rd, st, rs;
      logic [31:0] tv, rt;
      rs = ($urandom_range(0, 79) == 0);
      tr = ($urandom_range(0, 15) == 0);
      rd = ($urandom_range(0, 7) == 0);
      st = ($urandom_range(0, 3) == 0);
      tv = $urandom & 32'hFFFF_FFFC;
      rt = $urandom;
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      applyStimulus(tr, tv, rd, rt, st, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Program-counter generator; sits directly upstream of the instruction-fetch stage.
- Produces the fetch address each cycle and the flush/advance controls for the fetch pipeline register.
- Arbitrates sequential increment, execute-stage branch redirect, trap redirect and downstream stall.
- Tracks the PC of the instruction word fetch is delivering, so decode receives a matching PC.

Parameters:
XLEN, 32, datapath/address width
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
INCR, 4, byte increment per sequential fetch

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
stall_i  input  1  downstream backpressure; hold current fetch address
redirect_valid_i  input  1  branch/jump resolved taken in execute
redirect_target_i  input  XLEN  branch/jump target
trap_valid_i  input  1  trap/exception entry request
trap_vector_i  input  XLEN  trap handler address
target  output  XLEN  fetch address to fetch stage
flush  output  1  discard fetch pipeline contents this cycle
ok  output  1  fetch pipeline may advance this cycle
fetch_pc_o  output  XLEN  PC of the instruction word fetch is presenting
fetch_pc_valid_o  output  1  fetch_pc_o is meaningful
misalign_o  output  1  misaligned redirect detected (feature-dependent)

Behaviour:
- All outputs registered. Reset (rst=1 at an edge): target=RESET_VECTOR, flush=1, ok=0, fetch_pc_o=0, fetch_pc_valid_o=0, misalign_o=0, state=BOOT. Reset overrides every input, including mid-redirect and mid-stall.
- States: BOOT, RUN, STALL, REDIR, ERR.
- BOOT: lasts one cycle after reset deasserts. Outputs target=RESET_VECTOR, flush=0, ok=1. Then goes to RUN, unless an event below applies.
- Priority each cycle, highest first: trap_valid_i > redirect_valid_i > stall_i > sequential.
- Trap or redirect sampled at edge N:
  - cycle N+1: target=new address, flush=1, ok=0, fetch_pc_valid_o=0, state=REDIR.
  - cycle N+2: returns to RUN with ok=1.
  - A stall during REDIR is honoured only after this cycle: the redirect address is never lost.
- Back-to-back redirects: each restarts REDIR with the newest address. Trap and redirect in the same cycle: trap wins and the redirect is dropped.
- RUN with stall_i=0: target <= target+INCR, modulo 2^XLEN (wraps 0xFFFF_FFFC -> 0x0 at XLEN=32), ok=1, flush=0.
- stall_i=1 in RUN: state=STALL; target, fetch_pc_o and fetch_pc_valid_o hold; ok=0, flush=0. Leaving STALL (stall_i=0): target resumes increment from the held address in the following cycle; no address skipped, none duplicated.
- Redirect/trap during STALL: taken immediately (REDIR). The flush overrides the stall.
- fetch_pc tracking: at every edge where ok=1 and flush=0, fetch_pc_o <= target and fetch_pc_valid_o <= 1. This gives one-cycle alignment with the fetch pipeline register. flush=1 clears fetch_pc_valid_o at the next edge.
- ERR: exists only with the optional feature (see below).

Optional Feature:
Macro PC_GEN_MISALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_target_i[1:0]!=0 is not taken. Instead: state=ERR, misalign_o=1, ok=0, flush=1 for one cycle, then flush=0; target holds the old address.
  - ERR is sticky until trap_valid_i (normal trap redirect, clears misalign_o) or rst.
  - Stall and redirect are ignored in ERR.
  - Traps are never checked for alignment.
- Undefined: redirect_target_i[1:0] is forced to 2'b00, misalign_o tied 0, ERR unreachable.

Test Plan:
- Reset release, RESET_VECTOR=0x100, no stall, 4 cycles -> target 0x100,0x104,0x108,0x10C; ok=0 during reset then 1; fetch_pc_o lags target by one cycle.
- Run at 0x200, stall_i high 3 cycles -> target holds 0x200, ok=0 three cycles; after release targets 0x204,0x208 with no gap or duplicate.
- redirect_valid_i=1, target 0x400, while at 0x120 -> next cycle target=0x400, flush=1, ok=0, fetch_pc_valid_o=0 following cycle; then 0x404 with ok=1.
- trap_valid_i (vector 0x80) and redirect (0x400) in the same cycle during a stall -> target=0x80, flush=1; redirect dropped; sequence 0x84 after.
- Start from 0xFFFF_FFF8 via redirect -> 0xFFFF_FFFC, then 0x0000_0000 wrap.
- PC_GEN_MISALIGN_CHECK_EN defined, redirect to 0x402 -> misalign_o=1, ERR, ok=0; trap to 0x80 clears it. Undefined -> target=0x400, misalign_o=0.
